msg_scroller: RTL and testbench

MSG_SCROLLER -- requirements
Module: msg_scroller

---
 rtl/scroller_pkg.sv | 39 +++
 rtl/msg_rom.sv | 46 ++++
 rtl/msg_scroller.sv | 140 ++++++++++++++
 tb/tb_msg_scroller.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scroller_pkg.sv
// Shared types and constants for the message scroller: FSM states,
// character codes (0 = blank, A..Z = 1..26) and the stored message table.
package scroller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_FLUSH,
        ST_DONE
    } state_t;

    localparam logic [4:0] BLANK = 5'd0;
    localparam logic [4:0] CH_A = 5'd1,  CH_B = 5'd2,  CH_C = 5'd3,  CH_D = 5'd4;
    localparam logic [4:0] CH_E = 5'd5,  CH_F = 5'd6,  CH_G = 5'd7,  CH_H = 5'd8;
    localparam logic [4:0] CH_I = 5'd9,  CH_J = 5'd10, CH_K = 5'd11, CH_L = 5'd12;
    localparam logic [4:0] CH_M = 5'd13, CH_N = 5'd14, CH_O = 5'd15, CH_P = 5'd16;
    localparam logic [4:0] CH_Q = 5'd17, CH_R = 5'd18, CH_S = 5'd19, CH_T = 5'd20;
    localparam logic [4:0] CH_U = 5'd21, CH_V = 5'd22, CH_W = 5'd23, CH_X = 5'd24;
    localparam logic [4:0] CH_Y = 5'd25, CH_Z = 5'd26;

    localparam int MSG_WITHDRAW = 0;
    localparam int MSG_DEPOSIT  = 1;
    localparam int MSG_BALANCE  = 2;
    localparam int MSG_ERROR    = 3;

    localparam int NUM_STORED = 4;
    localparam int TEXT_MAX   = 8;

    // First character of each message sits at position 0.
    localparam logic [4:0] MSG_TEXT [NUM_STORED][TEXT_MAX] = '{
        '{CH_W, CH_I, CH_T, CH_H, CH_D, CH_R, CH_A, CH_W},
        '{CH_D, CH_E, CH_P, CH_O, CH_S, CH_I, CH_T, BLANK},
        '{CH_B, CH_A, CH_L, CH_A, CH_N, CH_C, CH_E, BLANK},
        '{CH_E, CH_R, CH_R, CH_O, CH_R, BLANK, BLANK, BLANK}
    };

    localparam int MSG_LEN [NUM_STORED] = '{8, 7, 7, 5};

endpackage

// File: rtl/msg_rom.sv
// Combinational message table lookup: (msg_sel, idx) -> character code and
// msg_sel -> message length. Out-of-range selections map to message 0.
module msg_rom
    import scroller_pkg::*;
#(
    parameter int CHAR_W   = 5,
    parameter int MSG_MAX  = 16,
    parameter int NUM_MSGS = 4,
    parameter int SEL_W    = (NUM_MSGS > 1) ? $clog2(NUM_MSGS) : 1,
    parameter int IDX_W    = $clog2(MSG_MAX + 1)
) (
    input  logic [SEL_W-1:0]  msg_sel,
    input  logic [IDX_W-1:0]  idx,
    output logic [CHAR_W-1:0] char_code,
    output logic [IDX_W-1:0]  len
);

    logic [1:0] slot;
    logic [2:0] pos;
    logic       stored;
    int         len_i;

    always_comb begin
        slot   = '0;
        stored = 1'b1;
        // Selections past the table but inside NUM_MSGS are empty messages.
        if (int'(msg_sel) < NUM_MSGS) begin
            if (int'(msg_sel) < NUM_STORED) begin
                slot = 2'(msg_sel);
            end else begin
                stored = 1'b0;
            end
        end
        len_i = stored ? MSG_LEN[slot] : 0;
        if (len_i > MSG_MAX) begin
            len_i = MSG_MAX;
        end
        len       = IDX_W'(len_i);
        pos       = 3'(idx);
        char_code = '0;
        if (int'(idx) < len_i) begin
            char_code = CHAR_W'(MSG_TEXT[slot][pos]);
        end
    end

endmodule

// File: rtl/msg_scroller.sv
// Scrolls a stored message through a WINDOW-character display, newest
// character in the LSBs, then flushes it out with blanks and pulses done.
module msg_scroller
    import scroller_pkg::*;
#(
    parameter int CHAR_W   = 5,
    parameter int WINDOW   = 8,
    parameter int MSG_MAX  = 16,
    parameter int NUM_MSGS = 4,
    parameter int SEL_W    = (NUM_MSGS > 1) ? $clog2(NUM_MSGS) : 1
) (
    input  logic                     sec_clock,
    input  logic                     rst,
    input  logic                     start,
    input  logic [SEL_W-1:0]         msg_sel,
    input  logic                     loop,
    input  logic                     hold,
    input  logic                     abort,
    output logic [CHAR_W*WINDOW-1:0] instruction,
    output logic                     busy,
    output logic                     done
);

    localparam int IDX_W  = $clog2(MSG_MAX + 1);
    localparam int DISP_W = CHAR_W * WINDOW;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   fcnt_q, fcnt_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [DISP_W-1:0]  instr_q, instr_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [SEL_W-1:0]   rom_sel;
    logic [CHAR_W-1:0]  rom_char;
    logic [IDX_W-1:0]   rom_len;
    logic               last_char;
    logic               last_blank;

    // In IDLE the length of the incoming selection decides SHIFT vs FLUSH.
    assign rom_sel = (state_q == ST_IDLE) ? msg_sel : sel_q;

    msg_rom #(
        .CHAR_W   (CHAR_W),
        .MSG_MAX  (MSG_MAX),
        .NUM_MSGS (NUM_MSGS),
        .SEL_W    (SEL_W),
        .IDX_W    (IDX_W)
    ) u_rom (
        .msg_sel   (rom_sel),
        .idx       (idx_q),
        .char_code (rom_char),
        .len       (rom_len)
    );

    assign last_char  = (idx_q == rom_len - IDX_W'(1));
    assign last_blank = (fcnt_q == IDX_W'(WINDOW - 1));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        fcnt_d  = fcnt_q;
        sel_d   = sel_q;
        instr_d = instr_q;
        if (abort) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            fcnt_d  = '0;
            instr_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        sel_d   = msg_sel;
                        idx_d   = '0;
                        fcnt_d  = '0;
                        state_d = (rom_len == '0) ? ST_FLUSH : ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (!hold) begin
                        instr_d = DISP_W'({instr_q, rom_char});
                        idx_d   = idx_q + IDX_W'(1);
                        if (last_char) begin
                            state_d = ST_FLUSH;
                            fcnt_d  = '0;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (!hold) begin
                        instr_d = DISP_W'({instr_q, {CHAR_W{1'b0}}});
                        fcnt_d  = fcnt_q + IDX_W'(1);
                        if (last_blank) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    idx_d  = '0;
                    fcnt_d = '0;
                    if (loop) begin
                        state_d = (rom_len == '0) ? ST_FLUSH : ST_SHIFT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge sec_clock or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            fcnt_q  <= '0;
            sel_q   <= '0;
            instr_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            fcnt_q  <= fcnt_d;
            sel_q   <= sel_d;
            instr_q <= instr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign instruction = instr_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_msg_scroller.sv
// Self-checking bench for msg_scroller: directed scenarios plus a randomized
// run against a queue-based reference model of the scrolling display.
module tb_msg_scroller;

    localparam int CHAR_W = 5;
    localparam int WINDOW = 8;
    localparam int DISP_W = CHAR_W * WINDOW;

    logic              sec_clock = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [1:0]        msg_sel = 2'd0;
    logic              loop = 1'b0;
    logic              hold = 1'b0;
    logic              abort = 1'b0;
    logic [DISP_W-1:0] instruction;
    logic              busy;
    logic              done;

    int n_cmp = 0;
    int n_bad = 0;

    msg_scroller #(
        .CHAR_W   (CHAR_W),
        .WINDOW   (WINDOW),
        .MSG_MAX  (16),
        .NUM_MSGS (4)
    ) dut (
        .sec_clock   (sec_clock),
        .rst         (rst),
        .start       (start),
        .msg_sel     (msg_sel),
        .loop        (loop),
        .hold        (hold),
        .abort       (abort),
        .instruction (instruction),
        .busy        (busy),
        .done        (done)
    );

    always #5 sec_clock = ~sec_clock;

    // Reference model: a pass is a queue of characters (text then WINDOW
    // blanks) consumed one per unheld edge; mode 0 idle, 1 running, 2 done.
    string             msg_text [4] = '{"WITHDRAW", "DEPOSIT", "BALANCE", "ERROR"};
    int                m_mode;
    logic [DISP_W-1:0] m_win;
    int                m_q[$];
    int                m_sel;

    function automatic void m_fill();
        string s;
        m_q.delete();
        s = msg_text[m_sel];
        for (int k = 0; k < s.len(); k++) m_q.push_back(int'(s[k]) - 64);
        for (int k = 0; k < WINDOW; k++) m_q.push_back(0);
    endfunction

    function automatic void m_reset();
        m_mode = 0;
        m_win  = '0;
        m_sel  = 0;
        m_q.delete();
    endfunction

    function automatic void m_step();
        int c;
        if (abort) begin
            m_mode = 0;
            m_win  = '0;
            m_q.delete();
        end else if (m_mode == 0) begin
            if (start) begin
                m_sel = int'(msg_sel);
                m_fill();
                m_mode = 1;
            end
        end else if (m_mode == 1) begin
            if (!hold) begin
                c = m_q.pop_front();
                m_win = {m_win[DISP_W-CHAR_W-1:0], 5'(c)};
                if (m_q.size() == 0) m_mode = 2;
            end
        end else begin
            if (loop) begin
                m_fill();
                m_mode = 1;
            end else begin
                m_mode = 0;
            end
        end
    endfunction

    task automatic tick();
        @(posedge sec_clock);
        m_step();
        #1;
    endtask

    task automatic test_reset();
        m_reset();
        #1;
        n_cmp++;
        if (instruction !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_async got instr=%h busy=%b done=%b want 0/0/0", instruction, busy, done);
        end
        repeat (2) @(posedge sec_clock);
        #1;
        n_cmp++;
        if (instruction !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_held got instr=%h busy=%b done=%b want 0/0/0", instruction, busy, done);
        end
        rst = 1'b0;
        $display("reset: released");
    endtask

    task automatic test_withdraw(input string tag);
        msg_sel = 2'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || instruction !== '0) begin
            n_bad++;
            $display("FAIL %s_accept got busy=%b instr=%h want busy=1 instr=0", tag, busy, instruction);
        end
        repeat (8) tick();
        n_cmp++;
        if (instruction !== 40'hBA68824837) begin
            n_bad++;
            $display("FAIL %s_full got=%h want=%h", tag, instruction, 40'hBA68824837);
        end
        repeat (8) tick();
        n_cmp++;
        if (instruction !== '0 || done !== 1'b1 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_done got instr=%h done=%b busy=%b want 0/1/1", tag, instruction, done, busy);
        end
        tick();
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_idle got busy=%b done=%b want 0/0", tag, busy, done);
        end
        $display("%s: pass complete", tag);
    endtask

    task automatic test_error();
        int e;
        msg_sel = 2'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        e = 1;
        repeat (5) begin tick(); e++; end
        n_cmp++;
        if (instruction[24:0] !== {5'd5, 5'd18, 5'd18, 5'd15, 5'd18} || instruction[39:25] !== '0) begin
            n_bad++;
            $display("FAIL error_text got=%h want=%h", instruction, {15'd0, 5'd5, 5'd18, 5'd18, 5'd15, 5'd18});
        end
        while (!done && e < 60) begin tick(); e++; end
        n_cmp++;
        if (e !== 14) begin
            n_bad++;
            $display("FAIL error_latency got=%0d edges want=14", e);
        end
        tick();
        $display("error: done after %0d edges", e);
    endtask

    task automatic test_hold();
        int e;
        logic [DISP_W-1:0] frozen;
        msg_sel = 2'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        e = 1;
        repeat (3) begin tick(); e++; end
        frozen = instruction;
        hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            e++;
            n_cmp++;
            if (instruction !== frozen) begin
                n_bad++;
                $display("FAIL hold_frozen[%0d] got=%h want=%h", k, instruction, frozen);
            end
        end
        hold = 1'b0;
        while (!done && e < 60) begin tick(); e++; end
        n_cmp++;
        if (e !== 20) begin
            n_bad++;
            $display("FAIL hold_latency got=%0d edges want=20", e);
        end
        tick();
        $display("hold: done after %0d edges", e);
    endtask

    task automatic test_loop();
        int e;
        int e1;
        loop = 1'b1;
        msg_sel = 2'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        e = 1;
        while (!done && e < 60) begin tick(); e++; end
        e1 = e;
        n_cmp++;
        if (e1 !== 16) begin
            n_bad++;
            $display("FAIL loop_first got=%0d edges want=16", e1);
        end
        tick();
        tick();
        e += 2;
        n_cmp++;
        if (instruction[4:0] !== 5'd4) begin
            n_bad++;
            $display("FAIL loop_restart got=%0d want=4", instruction[4:0]);
        end
        while (!done && e < 100) begin tick(); e++; end
        n_cmp++;
        if (e - e1 !== 16) begin
            n_bad++;
            $display("FAIL loop_period got=%0d want=16", e - e1);
        end
        loop = 1'b0;
        tick();
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL loop_stop got busy=%b done=%b want 0/0", busy, done);
        end
        $display("loop: period %0d edges", e - e1);
    endtask

    task automatic test_abort();
        int dones;
        msg_sel = 2'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        msg_sel = 2'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        n_cmp++;
        if (instruction[14:0] !== {5'd2, 5'd1, 5'd12} || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_ignore_start got=%h busy=%b want low=%h busy=1", instruction, busy, {5'd2, 5'd1, 5'd12});
        end
        abort = 1'b1;
        hold = 1'b1;
        tick();
        abort = 1'b0;
        hold = 1'b0;
        n_cmp++;
        if (instruction !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_clear got instr=%h busy=%b done=%b want 0/0/0", instruction, busy, done);
        end
        dones = 0;
        repeat (20) begin tick(); if (done === 1'b1) dones++; end
        n_cmp++;
        if (dones !== 0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_no_done got dones=%0d busy=%b want 0/0", dones, busy);
        end
        $display("abort: pass cancelled");
    endtask

    task automatic test_reset_mid_flush();
        msg_sel = 2'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (instruction !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_flush got instr=%h busy=%b done=%b want 0/0/0", instruction, busy, done);
        end
        m_reset();
        #1;
        rst = 1'b0;
        $display("reset_mid_flush: reset applied between edges");
        test_withdraw("after_reset");
    endtask

    task automatic test_random();
        int bad_before;
        bad_before = n_bad;
        for (int k = 0; k < 400; k++) begin
            start   = ($urandom_range(0, 99) < 30);
            msg_sel = 2'($urandom_range(0, 3));
            loop    = ($urandom_range(0, 99) < 20);
            hold    = ($urandom_range(0, 99) < 15);
            abort   = ($urandom_range(0, 99) < 3);
            tick();
            n_cmp++;
            if (instruction !== m_win || busy !== (m_mode != 0) || done !== (m_mode == 2)) begin
                n_bad++;
                $display("FAIL random[%0d] got instr=%h busy=%b done=%b want instr=%h busy=%b done=%b",
                         k, instruction, busy, done, m_win, (m_mode != 0), (m_mode == 2));
            end
        end
        start = 1'b0;
        loop  = 1'b0;
        hold  = 1'b0;
        abort = 1'b0;
        $display("random: 400 cycles, %0d new mismatches", n_bad - bad_before);
    endtask

    initial begin
        test_reset();
        test_withdraw("withdraw");
        test_error();
        test_hold();
        test_loop();
        test_abort();
        test_reset_mid_flush();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
